st_bus_arbiter: RTL and testbench
=================================

// Module: st_bus_arbiter
// PURPOSE
//  Sequences 68000-style bus arbitration between the CPU wrapper and up to four DMA masters
//  (ACSI/FDC DMA, blitter, ...) on the shared ST bus.
//  - CPU side: drives br_n and bgack_n; samples bg_n, as_n and dtack_n.
//  - Master side: one-hot req/gnt handshake.
//  - Phases: advances only on the phi1/phi2 enables of the system clock.
// PARAMETERS
//  N_MASTERS   2  number of DMA requesters, 1..4; index 0 has highest fixed priority
//  HOLDOFF     4  phi2 ticks the bus stays with the CPU after a release before re-arbitration, 1..15
// PORTS
//  clk       in   1          system clock
//  reset     in   1          synchronous, active-high reset
//  phi1      in   1          CPU phase-1 enable (one clk wide)
//  phi2      in   1          CPU phase-2 enable (one clk wide)
//  req       in   N_MASTERS  master bus requests, level; held for the whole tenure
//  gnt       out  N_MASTERS  one-hot grant; master may drive the bus only while high
//  owner     out  2          index of current/pending master
//  busy      out  1          1 in any state other than IDLE
//  br_n      out  1          bus request to CPU
//  bg_n      in   1          bus grant from CPU
//  bgack_n   out  1          bus grant acknowledge to CPU
//  as_n      in   1          bus address strobe
//  dtack_n   in   1          bus data acknowledge
// BEHAVIOUR
//  Reset: clk edge with reset=1. Effects:
//  - Outputs: br_n=1, bgack_n=1, gnt=0, owner=0, busy=0.
//  - Internal: state=IDLE, holdoff counter=0, rr pointer=0.
//  - Reset mid-tenure drops gnt/bgack_n in that same clk; no release sequence.
//  Sampling: bg_n, as_n, dtack_n are registered on phi1. All state transitions occur on phi2 only.
//  No events are processed on clks without phi1/phi2.
//  FSM:
//  - IDLE: on phi2 with req!=0:
//    - owner<=winner; br_n<=0 -> REQ.
//    - req==0: stay IDLE.
//  - REQ: on phi2:
//    - req[owner]==0 (withdrawn): br_n<=1 -> IDLE.
//    - else if sampled bg_n==0 -> WAIT.
//  - WAIT: on phi2 when sampled as_n==1 and dtack_n==1 (CPU cycle finished): bgack_n<=0, gnt[owner]<=1 -> OWN.
//    - Otherwise stay.
//    - A req drop here still completes entry to OWN, then releases on the next phi2.
//  - OWN:
//    - First phi2 in OWN: br_n<=1 (BR negated exactly one phi2 after BGACK asserted).
//    - On phi2 with req[owner]==0: gnt<=0, bgack_n<=1, load holdoff=HOLDOFF -> HOLD.
//    - Requests from other masters are ignored during OWN (no preemption, no direct handover).
//  - HOLD: counter decrements on each phi2; at 0 -> IDLE.
//    - The CPU regains the bus for at least HOLDOFF phi2 ticks between tenures.
//  Winner selection (fixed priority): lowest set index of req, evaluated at the IDLE->REQ phi2 only.
//  - Simultaneous requests resolve in that same tick.
//  - owner is frozen until the next IDLE exit.
//  Invariants:
//  - gnt is never high while bgack_n==1.
//  - At most one gnt bit is set.
//  - br_n and bgack_n are never both low for more than one phi2 tick.
//  - req bits >= N_MASTERS are absent; owner upper bits are 0 when N_MASTERS<=2.
// CONFIGURATION
//  ST_ARB_RR_EN:
//  - Defined: round-robin selection. Search starts at the index after the last granted owner, wrapping at N_MASTERS-1 -> 0.
//    - rr pointer updates on the IDLE->REQ phi2.
//    - Reset sets the pointer so index 0 wins first.
//  - Undefined: fixed priority as above; no pointer register is synthesised.
//  All other behaviour is identical in both builds.
// TESTING
//  Reset while in OWN with gnt=01:
//  - Next clk: gnt=0, bgack_n=1, br_n=1, busy=0.
//  Single request: req=01, CPU returns bg_n=0 two phi2 later, as_n=dtack_n=1. Required:
//  - br_n low on the first phi2.
//  - bgack_n low and gnt=01 on the phi2 after bg_n is sampled.
//  - br_n high one phi2 later.
//  Bus-cycle wait: bg_n=0 while as_n=0 for 3 phi2 ticks:
//  - bgack_n stays 1 and gnt=0 until the phi2 after as_n and dtack_n are both sampled 1.
//  Release and holdoff: HOLDOFF=4, drop req[0] in OWN while req[1]=1:
//  - gnt=0 and bgack_n=1 at that phi2.
//  - br_n goes low again exactly 5 phi2 ticks later with owner=1.
//  Withdrawal: req=01 in REQ, dropped before bg_n goes low -> br_n=1 and state IDLE at next phi2.
//  Arbitration with req=11 held, each tenure 2 phi2 ticks:
//  - Fixed priority: owner sequence 0,0,0.
//  - With ST_ARB_RR_EN: owner sequence 0,1,0.

Source files
------------

// File: rtl/st_bus_arbiter.sv
// st_bus_arbiter: 68000-style BR/BG/BGACK bus arbitration between the CPU and up to four DMA masters.
// Define ST_ARB_RR_EN for round-robin master selection; fixed priority (index 0 highest) otherwise.
module st_bus_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int HOLDOFF   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 phi1,
  input  logic                 phi2,
  input  logic [N_MASTERS-1:0] req,
  output logic [N_MASTERS-1:0] gnt,
  output logic [1:0]           owner,
  output logic                 busy,
  output logic                 br_n,
  input  logic                 bg_n,
  output logic                 bgack_n,
  input  logic                 as_n,
  input  logic                 dtack_n
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, OWN, HOLD} state_t;
  state_t               state_q, state_d;
  logic [N_MASTERS-1:0] gnt_q, gnt_d, own_oh;
  logic [1:0]           owner_q, owner_d, win;
  logic                 br_n_q, br_n_d, bgack_n_q, bgack_n_d;
  logic                 bg_s_q, bg_s_d, as_s_q, as_s_d, dtack_s_q, dtack_s_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 req_own;
  assign own_oh  = N_MASTERS'(1) << owner_q;
  assign req_own = |(req & own_oh);
  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign busy    = state_q != IDLE;
  assign br_n    = br_n_q;
  assign bgack_n = bgack_n_q;
`ifdef ST_ARB_RR_EN
  logic [1:0] rr_q, rr_d;
  logic [2:0] j;
  // descending scan so the index closest after rr_q is written last and wins
  always_comb begin
    win = '0;
    j   = '0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      j = 3'(rr_q) + 3'(k);
      if (j >= 3'(N_MASTERS)) j = j - 3'(N_MASTERS);
      if (|(req & (N_MASTERS'(1) << j))) win = j[1:0];
    end
  end
`else
  always_comb begin
    win = '0;
    for (int k = N_MASTERS - 1; k >= 0; k--)
      if (req[k]) win = 2'(k);
  end
`endif
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    br_n_d    = br_n_q;
    bgack_n_d = bgack_n_q;
    cnt_d     = cnt_q;
    bg_s_d    = phi1 ? bg_n : bg_s_q;
    as_s_d    = phi1 ? as_n : as_s_q;
    dtack_s_d = phi1 ? dtack_n : dtack_s_q;
`ifdef ST_ARB_RR_EN
    rr_d      = rr_q;
`endif
    if (phi2) begin
      case (state_q)
        IDLE: if (|req) begin
          owner_d = win;
          br_n_d  = 1'b0;
          state_d = REQ;
`ifdef ST_ARB_RR_EN
          rr_d    = (win == 2'(N_MASTERS - 1)) ? 2'd0 : win + 2'd1;
`endif
        end
        REQ: if (!req_own) begin
          br_n_d  = 1'b1;
          state_d = IDLE;
        end else if (!bg_s_q) state_d = WAIT;
        WAIT: if (as_s_q && dtack_s_q) begin
          bgack_n_d = 1'b0;
          gnt_d     = own_oh;
          state_d   = OWN;
        end
        OWN: begin
          br_n_d = 1'b1;
          if (!req_own) begin
            gnt_d     = '0;
            bgack_n_d = 1'b1;
            cnt_d     = 4'(HOLDOFF);
            state_d   = HOLD;
          end
        end
        HOLD: begin
          cnt_d   = cnt_q - 4'd1;
          state_d = (cnt_q == 4'd1) ? IDLE : HOLD;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      br_n_q    <= 1'b1;
      bgack_n_q <= 1'b1;
      cnt_q     <= '0;
      bg_s_q    <= 1'b1;
      as_s_q    <= 1'b1;
      dtack_s_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      br_n_q    <= br_n_d;
      bgack_n_q <= bgack_n_d;
      cnt_q     <= cnt_d;
      bg_s_q    <= bg_s_d;
      as_s_q    <= as_s_d;
      dtack_s_q <= dtack_s_d;
    end
  end
`ifdef ST_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset) rr_q <= '0;
    else rr_q <= rr_d;
  end
`endif
endmodule

// File: tb/tb_st_bus_arbiter.sv
// tb_st_bus_arbiter: table-driven scoreboard bench for st_bus_arbiter (N_MASTERS=2, HOLDOFF=4).
module tb_st_bus_arbiter;
  logic       clk = 1'b0, reset = 1'b1, phi1 = 1'b0, phi2 = 1'b0;
  logic       bg_n = 1'b1, as_n = 1'b1, dtack_n = 1'b1;
  logic [1:0] req = 2'b00, gnt, owner;
  logic       busy, br_n, bgack_n;

  always #5 clk = ~clk;

  st_bus_arbiter #(.N_MASTERS(2), .HOLDOFF(4)) dut (
    .clk(clk), .reset(reset), .phi1(phi1), .phi2(phi2), .req(req), .gnt(gnt),
    .owner(owner), .busy(busy), .br_n(br_n), .bg_n(bg_n), .bgack_n(bgack_n),
    .as_n(as_n), .dtack_n(dtack_n)
  );

  typedef struct packed {
    logic [1:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       br_n;
    logic       bgack_n;
  } out_t;

  typedef struct {
    logic [1:0] req;
    logic       bg_n, as_n, dtack_n;
    out_t       exp;
    string      name;
  } vec_t;

  vec_t  tbl[$];
  out_t  exp_q[$];
  string name_q[$];
  int    errors = 0, checks = 0;

  function automatic out_t o(input logic [1:0] g, input logic [1:0] ow, input logic b, input logic br, input logic ba);
    return {g, ow, b, br, ba};
  endfunction

  task automatic add(input logic [1:0] r, input logic bg, input logic as_i, input logic dt, input out_t e, input string nm);
    vec_t v;
    v.req = r; v.bg_n = bg; v.as_n = as_i; v.dtack_n = dt; v.exp = e; v.name = nm;
    tbl.push_back(v);
  endtask

  task automatic check_out();
    out_t e, a;
    string nm;
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    a  = {gnt, owner, busy, br_n, bgack_n};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got gnt=%b owner=%0d busy=%b br_n=%b bgack_n=%b, want gnt=%b owner=%0d busy=%b br_n=%b bgack_n=%b",
               nm, a.gnt, a.owner, a.busy, a.br_n, a.bgack_n, e.gnt, e.owner, e.busy, e.br_n, e.bgack_n);
    end
  endtask

  // one CPU phase cycle: phi1 clk, idle clk, phi2 clk; returns #1 after the phi2 edge
  task automatic tick();
    phi1 = 1'b1;
    @(posedge clk); #1 phi1 = 1'b0;
    @(posedge clk); #1 phi2 = 1'b1;
    @(posedge clk); #1 phi2 = 1'b0;
  endtask

  task automatic step(input logic [1:0] r, input logic bg, input logic as_i, input logic dt, input out_t e, input string nm);
    req = r; bg_n = bg; as_n = as_i; dtack_n = dt;
    exp_q.push_back(e);
    name_q.push_back(nm);
    tick();
    check_out();
  endtask

  task automatic do_reset(input string nm);
    reset = 1'b1;
    exp_q.push_back(o(2'b00, 2'd0, 1'b0, 1'b1, 1'b1));
    name_q.push_back(nm);
    @(posedge clk); #1;
    check_out();
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if ((gnt != 2'b00 && bgack_n) || $countones(gnt) > 1) begin
        errors++;
        $display("FAIL invariant: got gnt=%b bgack_n=%b, want one-hot gnt only with bgack_n=0", gnt, bgack_n);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] ow;
    logic [1:0] arb_seq[3];
`ifdef ST_ARB_RR_EN
    arb_seq = '{2'd0, 2'd1, 2'd0};
`else
    arb_seq = '{2'd0, 2'd0, 2'd0};
`endif
    // single request, grant, release with master 1 waiting, holdoff, then withdrawal in REQ
    add(2'b01, 1, 1, 1, o(2'b00, 0, 1, 0, 1), "single_br_low");
    add(2'b01, 0, 1, 1, o(2'b00, 0, 1, 0, 1), "single_bg_seen");
    add(2'b01, 0, 1, 1, o(2'b01, 0, 1, 0, 0), "single_bgack");
    add(2'b01, 0, 1, 1, o(2'b01, 0, 1, 1, 0), "single_br_release");
    add(2'b11, 0, 1, 1, o(2'b01, 0, 1, 1, 0), "own_no_preempt");
    add(2'b10, 1, 1, 1, o(2'b00, 0, 1, 1, 1), "release");
    add(2'b10, 1, 1, 1, o(2'b00, 0, 1, 1, 1), "hold1");
    add(2'b10, 1, 1, 1, o(2'b00, 0, 1, 1, 1), "hold2");
    add(2'b10, 1, 1, 1, o(2'b00, 0, 1, 1, 1), "hold3");
    add(2'b10, 1, 1, 1, o(2'b00, 0, 0, 1, 1), "hold_done");
    add(2'b10, 1, 1, 1, o(2'b00, 1, 1, 0, 1), "rearb_owner1");
    add(2'b10, 1, 1, 1, o(2'b00, 1, 1, 0, 1), "req_no_bg");
    add(2'b00, 1, 1, 1, o(2'b00, 1, 0, 1, 1), "withdraw");
    // request dropped while waiting still enters OWN, then releases
    add(2'b01, 1, 1, 1, o(2'b00, 0, 1, 0, 1), "wdrop_req");
    add(2'b01, 0, 0, 1, o(2'b00, 0, 1, 0, 1), "wdrop_wait");
    add(2'b00, 0, 1, 1, o(2'b01, 0, 1, 0, 0), "wdrop_own");
    add(2'b00, 1, 1, 1, o(2'b00, 0, 1, 1, 1), "wdrop_release");
    add(2'b00, 1, 1, 1, o(2'b00, 0, 1, 1, 1), "wdrop_hold1");
    add(2'b00, 1, 1, 1, o(2'b00, 0, 1, 1, 1), "wdrop_hold2");
    add(2'b00, 1, 1, 1, o(2'b00, 0, 1, 1, 1), "wdrop_hold3");
    add(2'b00, 1, 1, 1, o(2'b00, 0, 0, 1, 1), "wdrop_idle");
    // CPU bus cycle in progress delays the grant acknowledge
    add(2'b01, 1, 1, 1, o(2'b00, 0, 1, 0, 1), "bcw_req");
    add(2'b01, 0, 0, 1, o(2'b00, 0, 1, 0, 1), "bcw_as_low1");
    add(2'b01, 0, 0, 1, o(2'b00, 0, 1, 0, 1), "bcw_as_low2");
    add(2'b01, 0, 0, 0, o(2'b00, 0, 1, 0, 1), "bcw_as_low3");
    add(2'b01, 0, 1, 0, o(2'b00, 0, 1, 0, 1), "bcw_dtack_low");
    add(2'b01, 0, 1, 1, o(2'b01, 0, 1, 0, 0), "bcw_grant");

    do_reset("reset_initial");
    foreach (tbl[i]) step(tbl[i].req, tbl[i].bg_n, tbl[i].as_n, tbl[i].dtack_n, tbl[i].exp, tbl[i].name);

    do_reset("reset_mid_tenure");
    for (int t = 0; t < 3; t++) begin
      ow = arb_seq[t];
      step(2'b11, 1, 1, 1, o(2'b00, ow, 1, 0, 1), $sformatf("arb%0d_req", t));
      step(2'b11, 0, 1, 1, o(2'b00, ow, 1, 0, 1), $sformatf("arb%0d_wait", t));
      step(2'b11, 0, 1, 1, o(2'b01 << ow, ow, 1, 0, 0), $sformatf("arb%0d_own", t));
      step(2'b11, 0, 1, 1, o(2'b01 << ow, ow, 1, 1, 0), $sformatf("arb%0d_own_br", t));
      step(2'b11 & ~(2'b01 << ow), 1, 1, 1, o(2'b00, ow, 1, 1, 1), $sformatf("arb%0d_release", t));
      for (int h = 0; h < 4; h++)
        step(2'b11, 1, 1, 1, o(2'b00, ow, (h == 3) ? 1'b0 : 1'b1, 1, 1), $sformatf("arb%0d_hold%0d", t, h));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
